mips_cpu_cycle_sequencer: RTL and testbench

//  State register and next-state logic for the multicycle MIPS core. Classifies the fetched opcode/fncode.

---
 rtl/mips_cpu_pkg.sv | 53 +++++
 rtl/mips_cpu_instr_class.sv | 32 +++
 rtl/mips_cpu_cycle_sequencer.sv | 101 ++++++++++
 tb/tb_mips_cpu_cycle_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and opcode constants for the multicycle MIPS core.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LINK,
    CL_LOAD,
    CL_STORE,
    CL_FLOW,
    CL_ILLEGAL
  } instr_class_t;

  // R-type fncodes executed by the ALU path: shifts, HI/LO moves,
  // mult/div, add/sub, logic ops and set-less-than.
  function automatic logic fn_is_arith(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h10, 6'h11, 6'h12, 6'h13,
      6'h18, 6'h19, 6'h1A, 6'h1B,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: fn_is_arith = 1'b1;
      default:      fn_is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational opcode/fncode classifier, shared with the control decoder.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   fncode,
  output instr_class_t instr_class
);

  // Map the instruction fields onto the sequencing class.
  always_comb begin
    instr_class = CL_ILLEGAL;
    if (opcode == OP_RTYPE) begin
      if (fncode == FN_JR)            instr_class = CL_FLOW;
      else if (fncode == FN_JALR)     instr_class = CL_LINK;
      else if (fn_is_arith(fncode))   instr_class = CL_ALU;
    end else if (opcode == OP_REGIMM || opcode == OP_JAL) begin
      instr_class = CL_LINK;
    end else if (opcode == OP_J) begin
      instr_class = CL_FLOW;
    end else if (opcode >= OP_BEQ && opcode <= OP_BGTZ) begin
      instr_class = CL_FLOW;
    end else if (opcode >= OP_ADDI && opcode <= OP_LUI) begin
      instr_class = CL_ALU;
    end else if (opcode >= OP_LB && opcode <= OP_LWR) begin
      instr_class = CL_LOAD;
    end else if (opcode == OP_SB || opcode == OP_SH || opcode == OP_SW) begin
      instr_class = CL_STORE;
    end
  end

endmodule

// File: rtl/mips_cpu_cycle_sequencer.sv
// State register and next-state logic of the multicycle MIPS core.
// Handshake: mem_waitrequest=1 means memory has not accepted/returned the
// access this cycle; FETCH and MEM hold until a cycle with waitrequest=0,
// and that cycle completes the access. Elsewhere waitrequest is ignored.
module mips_cpu_cycle_sequencer
  import mips_cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fncode,
  input  logic             mem_waitrequest,
  input  logic             pc_next_zero,
  output logic [2:0]       state,
  output logic             active,
  output logic             instr_done,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count
);

  state_t           state_q, state_d;
  logic             active_q, active_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  instr_class_t     cls;

  mips_cpu_instr_class u_class (
    .opcode      (opcode),
    .fncode      (fncode),
    .instr_class (cls)
  );

  // State, fault flag and active-cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      active_q      <= 1'b1;
      fault_q       <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      fault_q       <= fault_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next-state selection; a retiring instruction halts if it commits PC 0.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH:  state_d = mem_waitrequest ? ST_FETCH : ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CL_ALU, CL_LINK:    state_d = ST_WB;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          CL_FLOW:            state_d = pc_next_zero ? ST_HALT : ST_FETCH;
          default: begin
            // Illegal wins over pc_next_zero and never retires.
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (!mem_waitrequest) begin
          if (cls == CL_STORE) state_d = pc_next_zero ? ST_HALT : ST_FETCH;
          else                 state_d = ST_WB;
        end
      end
      ST_WB:   state_d = pc_next_zero ? ST_HALT : ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end
    endcase
    active_d      = (state_d != ST_HALT);
    cycle_count_d = (state_q != ST_HALT) ? cycle_count_q + CNT_W'(1) : cycle_count_q;
  end

  // Outputs: retire pulse decoded from state and class, the rest registered.
  always_comb begin
    instr_done = 1'b0;
    case (state_q)
      ST_EXEC: instr_done = (cls == CL_FLOW);
      ST_MEM:  instr_done = (cls == CL_STORE) && !mem_waitrequest;
      ST_WB:   instr_done = 1'b1;
      default: instr_done = 1'b0;
    endcase
    state       = state_q;
    active      = active_q;
    fault       = fault_q;
    cycle_count = cycle_count_q;
  end

endmodule

// File: tb/tb_mips_cpu_cycle_sequencer.sv
// Bench for the multicycle sequencer: each instruction is expanded into its
// expected per-cycle state list from the class/latency rules, then replayed.
module tb_mips_cpu_cycle_sequencer;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam int C_ALU = 0, C_LINK = 1, C_LOAD = 2, C_STORE = 3, C_FLOW = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, fncode;
  logic        mem_waitrequest, pc_next_zero;
  logic [2:0]  state;
  logic        active, instr_done, fault;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;
  int model_count;
  bit model_fault;
  bit model_halted;

  mips_cpu_cycle_sequencer #(.CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .fncode          (fncode),
    .mem_waitrequest (mem_waitrequest),
    .pc_next_zero    (pc_next_zero),
    .state           (state),
    .active          (active),
    .instr_done      (instr_done),
    .fault           (fault),
    .cycle_count     (cycle_count)
  );

  // Clock.
  always #5 clk = ~clk;

  // Instruction class from the ISA subset rules.
  function automatic int ref_class(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08) return C_FLOW;
      if (fn == 6'h09) return C_LINK;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12,
                     6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23,
                     6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}) return C_ALU;
      return C_ILL;
    end
    if (op == 6'h01 || op == 6'h03) return C_LINK;
    if (op == 6'h02 || (op >= 6'h04 && op <= 6'h07)) return C_FLOW;
    if (op >= 6'h08 && op <= 6'h0F) return C_ALU;
    if (op >= 6'h20 && op <= 6'h26) return C_LOAD;
    if (op == 6'h28 || op == 6'h29 || op == 6'h2B) return C_STORE;
    return C_ILL;
  endfunction

  // Common per-cycle output comparison against the model.
  task automatic check_cycle(input string tag, input logic [2:0] exp_state,
                             input logic exp_active, input logic exp_done);
    checks++;
    if (state !== exp_state) begin
      failures++;
      $display("FAIL %s state: got %0d want %0d (t=%0t)", tag, state, exp_state, $time);
    end
    checks++;
    if (active !== exp_active) begin
      failures++;
      $display("FAIL %s active: got %b want %b (t=%0t)", tag, active, exp_active, $time);
    end
    checks++;
    if (instr_done !== exp_done) begin
      failures++;
      $display("FAIL %s instr_done: got %b want %b (t=%0t)", tag, instr_done, exp_done, $time);
    end
    checks++;
    if (fault !== model_fault) begin
      failures++;
      $display("FAIL %s fault: got %b want %b (t=%0t)", tag, fault, model_fault, $time);
    end
    checks++;
    if (cycle_count !== 32'(model_count)) begin
      failures++;
      $display("FAIL %s cycle_count: got %0d want %0d (t=%0t)", tag, cycle_count, model_count, $time);
    end
  endtask

  // Enter and leave at a falling edge; releases reset right before a fetch edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    mem_waitrequest = 1'($urandom_range(0, 1));
    #1;
    model_count = 0;
    model_fault = 1'b0;
    model_halted = 1'b0;
    check_cycle("reset", S_FETCH, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Replay one instruction; abort_at >= 0 stops mid-instruction after that cycle's check.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input bit pcz, input int abort_at);
    logic [2:0] exp_q[$];
    int cls;
    int first_mem;
    int last;
    bit is_last;
    cls = ref_class(op, fn);
    exp_q = {};
    for (int k = 0; k <= fw; k++) exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    exp_q.push_back(S_EXEC);
    first_mem = exp_q.size();
    if (cls == C_LOAD || cls == C_STORE)
      for (int k = 0; k <= mw; k++) exp_q.push_back(S_MEM);
    if (cls == C_ALU || cls == C_LINK || cls == C_LOAD) exp_q.push_back(S_WB);
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      is_last = (i == last);
      opcode = (i > fw) ? op : 6'($urandom_range(0, 63));
      fncode = (i > fw) ? fn : 6'($urandom_range(0, 63));
      if (exp_q[i] == S_FETCH)    mem_waitrequest = (i < fw);
      else if (exp_q[i] == S_MEM) mem_waitrequest = ((i - first_mem) < mw);
      else                        mem_waitrequest = 1'($urandom_range(0, 1));
      pc_next_zero = (is_last && cls != C_ILL) ? pcz : 1'($urandom_range(0, 1));
      #1;
      check_cycle(tag, exp_q[i], 1'b1, is_last && cls != C_ILL);
      model_count++;
      if (i == abort_at) return;
      @(negedge clk);
    end
    if (cls == C_ILL) begin
      model_fault = 1'b1;
      model_halted = 1'b1;
    end else if (pcz) begin
      model_halted = 1'b1;
    end
  endtask

  // HALT must absorb everything with the counter frozen.
  task automatic check_halt(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom_range(0, 63));
      fncode = 6'($urandom_range(0, 63));
      mem_waitrequest = 1'($urandom_range(0, 1));
      pc_next_zero = 1'($urandom_range(0, 1));
      #1;
      check_cycle(tag, S_HALT, 1'b0, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu();
    run_instr("addu", 6'h00, 6'h21, 0, 0, 1'b0, -1);
    checks++;
    if (cycle_count !== 32'd4) begin
      failures++;
      $display("FAIL addu_count: got %0d want 4", cycle_count);
    end
    run_instr("addiu", 6'h09, 6'h00, 1, 0, 1'b0, -1);
    run_instr("jal", 6'h03, 6'h00, 0, 0, 1'b0, -1);
  endtask

  task automatic test_load();
    run_instr("lw_stall", 6'h23, 6'h00, 2, 3, 1'b0, -1);
  endtask

  task automatic test_store();
    run_instr("sw", 6'h2B, 6'h00, 0, 0, 1'b0, -1);
    run_instr("sb_stall", 6'h28, 6'h00, 1, 2, 1'b0, -1);
    run_instr("beq", 6'h04, 6'h00, 0, 0, 1'b0, -1);
  endtask

  task automatic test_halt_jr();
    do_reset();
    run_instr("jr_pc0", 6'h00, 6'h08, 0, 0, 1'b1, -1);
    check_halt("halt_jr", 20);
    checks++;
    if (cycle_count !== 32'd3) begin
      failures++;
      $display("FAIL halt_count: got %0d want 3", cycle_count);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr("illegal_3f", 6'h3F, 6'h00, 0, 0, 1'b0, -1);
    check_halt("halt_illegal", 5);
    do_reset();
    run_instr("after_illegal", 6'h00, 6'h21, 0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    run_instr("lw_abort", 6'h23, 6'h00, 0, 10, 1'b0, 5);
    do_reset();
    run_instr("addu_after", 6'h00, 6'h21, 0, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) op = 6'h00;
      fn = 6'($urandom_range(0, 63));
      run_instr("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0), -1);
      if (model_halted) begin
        check_halt("random_halt", 3);
        do_reset();
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    rst_n = 1'b0;
    opcode = '0;
    fncode = '0;
    mem_waitrequest = 1'b0;
    pc_next_zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_halt_jr();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
